// File: rtl/dac_window_discriminator.sv
// rtl/dac_window_discriminator.sv - trigger-then-window spike discriminator on a DAC sample stream
// Optional refractory period after a detect is enabled by defining DAC_WIN_DISC_REFRACTORY_EN.
module dac_window_discriminator #(
  parameter int DATA_W  = 16,
  parameter int NUM_WIN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      dataclk,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic [DATA_W-1:0]         sample,
  input  logic                      enable,
  input  logic [DATA_W-1:0]         trig_thrsh,
  input  logic                      trig_pol,
  input  logic [NUM_WIN*DATA_W-1:0] win_thrsh,
  input  logic [NUM_WIN-1:0]        win_pol,
  input  logic [NUM_WIN-1:0]        edge_type,
  input  logic [NUM_WIN-1:0]        win_en,
  input  logic [NUM_WIN*CNT_W-1:0]  start_win,
  input  logic [NUM_WIN*CNT_W-1:0]  stop_win,
  input  logic [CNT_W-1:0]          stop_max,
`ifdef DAC_WIN_DISC_REFRACTORY_EN
  input  logic [CNT_W-1:0]          refractory,
`endif
  output logic                      detect,
  output logic [NUM_WIN-1:0]        win_hit,
  output logic                      busy,
  output logic [1:0]                fsm_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [1:0]         eval_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cur_off;
  logic               trig_x;
  logic               take_sample;
  logic               last_sample;
  logic               all_pass;
  logic [NUM_WIN-1:0] hit_now;
  logic [NUM_WIN-1:0] hits_acc;
  logic [NUM_WIN-1:0] pass;
`ifdef DAC_WIN_DISC_REFRACTORY_EN
  logic [CNT_W-1:0]   refr_cnt;
`endif

  // cnt holds the offset of the last accepted sample; the trigger sample is offset 0
  assign cur_off = (state == S_TRACK) ? cnt + CNT_W'(1) : '0;
  assign trig_x  = trig_pol ? (sample > trig_thrsh) : (sample < trig_thrsh);

  always_comb begin
    hit_now = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      hit_now[i] = win_en[i]
                 && (start_win[i*CNT_W +: CNT_W] <= cur_off)
                 && (cur_off <= stop_win[i*CNT_W +: CNT_W])
                 && (win_pol[i] ? (sample > win_thrsh[i*DATA_W +: DATA_W])
                                : (sample < win_thrsh[i*DATA_W +: DATA_W]));
    end
  end

  assign take_sample = sample_valid && enable
                     && (((state == S_IDLE) && trig_x) || (state == S_TRACK));
  // >= rather than == so a mid-event drop of stop_max still terminates the event
  assign last_sample = take_sample && (cur_off >= stop_max);
  assign hits_acc    = ((state == S_TRACK) ? win_hit : '0) | hit_now;
  assign pass        = (hits_acc ^ edge_type) | ~win_en;
  assign all_pass    = &pass;

`ifdef DAC_WIN_DISC_REFRACTORY_EN
  assign eval_nxt = (all_pass && (refractory != '0)) ? S_REFRACT : S_IDLE;
`else
  assign eval_nxt = S_IDLE;
`endif

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_sample) state_nxt = last_sample ? eval_nxt : S_TRACK;
      end
      S_TRACK: begin
        if (!enable)          state_nxt = S_IDLE;
        else if (last_sample) state_nxt = eval_nxt;
      end
`ifdef DAC_WIN_DISC_REFRACTORY_EN
      S_REFRACT: begin
        if (!enable)                                     state_nxt = S_IDLE;
        else if (sample_valid && (refr_cnt <= CNT_W'(1))) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    fsm_state = state;
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      win_hit <= '0;
      detect  <= 1'b0;
    end else begin
      detect <= last_sample && all_pass;
      if (take_sample) begin
        win_hit <= hits_acc;
        cnt     <= last_sample ? '0 : cur_off;
      end
    end
  end

`ifdef DAC_WIN_DISC_REFRACTORY_EN
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      refr_cnt <= '0;
    end else if ((state != S_REFRACT) && (state_nxt == S_REFRACT)) begin
      refr_cnt <= refractory;
    end else if ((state == S_REFRACT) && sample_valid && (refr_cnt != '0)) begin
      refr_cnt <= refr_cnt - CNT_W'(1);
    end
  end
`endif

endmodule
